// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: combinational CSR read for Execute,
// writeback commits, mcycle/minstret, interrupt sampling, trap entry and MRET.
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] destinationCSR,
  output logic [31:0] csrReadData,
  input  logic        csrWriteEnable,
  input  logic [11:0] csrWriteAddress,
  input  logic [31:0] csrWriteData,
  input  logic        retireValid,
  input  logic [31:0] retireNextPC,
  input  logic        exceptionValid,
  input  logic [3:0]  exceptionCause,
  input  logic [31:0] exceptionPC,
  input  logic [31:0] exceptionTval,
  input  logic        mretCommit,
  input  logic        softwareInterrupt,
  input  logic        timerInterrupt,
  input  logic        externalInterrupt,
  output logic        trapRedirect,
  output logic [31:0] trapTarget,
  output logic        interruptPending
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic                gie_q, gie_d;
  logic                mpie_q, mpie_d;
  logic [31:0]         mie_q, mie_d;
  logic [31:0]         mtvec_q, mtvec_d;
  logic [31:0]         mscratch_q, mscratch_d;
  logic [31:0]         mepc_q, mepc_d;
  logic [31:0]         mcause_q, mcause_d;
  logic [31:0]         mtval_q, mtval_d;
  logic [31:0]         mcycle_q, mcycle_d;
  logic [31:0]         minstret_q, minstret_d;
  logic                msip_q, mtip_q;
  logic [SYNC_N-1:0]   meip_sync_q;

  logic        run;
  logic [31:0] mstatus, mip, irq_act, irq_cause;
  logic        take_exc, take_irq, take_trap, do_mret, do_wr;

  // MPP is hard-wired to M-mode; only MIE/MPIE are stored.
  assign mstatus = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, gie_q, 3'b0};
  assign mip     = {20'b0, meip_sync_q[SYNC_N-1], 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
  assign irq_act = mip & mie_q;
  assign interruptPending = gie_q && (|irq_act);
  assign irq_cause = irq_act[11] ? 32'h8000_000B :
                     irq_act[3]  ? 32'h8000_0003 : 32'h8000_0007;

  assign take_exc  = run && exceptionValid;
  assign take_irq  = run && !exceptionValid && interruptPending && retireValid;
  assign take_trap = take_exc || take_irq;
  assign do_mret   = run && !take_trap && mretCommit;
  assign do_wr     = run && !take_trap && !mretCommit && csrWriteEnable;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (take_trap) state_d = S_FLUSH;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    run          = (state_q == S_RUN);
    trapRedirect = (state_q == S_FLUSH);
  end

  assign trapTarget = mtvec_q;

  always_comb begin
    gie_d      = gie_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 32'd1;
    // An interrupt trap still retires the instruction; an exception does not.
    minstret_d = minstret_q + {31'b0, run && retireValid && !exceptionValid};
    if (take_trap) begin
      mpie_d = gie_q;
      gie_d  = 1'b0;
      if (take_exc) begin
        mepc_d   = exceptionPC;
        mcause_d = {28'b0, exceptionCause};
        mtval_d  = exceptionTval;
      end else begin
        mepc_d   = retireNextPC;
        mcause_d = irq_cause;
        mtval_d  = 32'b0;
      end
    end else if (do_mret) begin
      gie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (do_wr) begin
      case (csrWriteAddress)
        CSR_MSTATUS:  begin gie_d = csrWriteData[3]; mpie_d = csrWriteData[7]; end
        CSR_MIE:      mie_d      = csrWriteData & 32'h0000_0888;
        CSR_MTVEC:    mtvec_d    = csrWriteData & ~32'd3;
        CSR_MSCRATCH: mscratch_d = csrWriteData;
        CSR_MEPC:     mepc_d     = csrWriteData & ~32'd3;
        CSR_MCAUSE:   mcause_d   = csrWriteData;
        CSR_MTVAL:    mtval_d    = csrWriteData;
        CSR_MCYCLE:   mcycle_d   = csrWriteData;
        CSR_MINSTRET: minstret_d = csrWriteData;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      mie_q       <= '0;
      mtvec_q     <= RESET_MTVEC & ~32'd3;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
      msip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      meip_sync_q <= '0;
    end else begin
      gie_q       <= gie_d;
      mpie_q      <= mpie_d;
      mie_q       <= mie_d;
      mtvec_q     <= mtvec_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      msip_q      <= softwareInterrupt;
      mtip_q      <= timerInterrupt;
      meip_sync_q <= {meip_sync_q[SYNC_N-2:0], externalInterrupt};
    end
  end

  // No write bypass: Execute forwards in-flight CSR writes itself.
  always_comb begin
    csrReadData = '0;
    case (destinationCSR)
      CSR_MSTATUS:  csrReadData = mstatus;
      CSR_MIE:      csrReadData = mie_q;
      CSR_MTVEC:    csrReadData = mtvec_q;
      CSR_MSCRATCH: csrReadData = mscratch_q;
      CSR_MEPC:     csrReadData = mepc_q;
      CSR_MCAUSE:   csrReadData = mcause_q;
      CSR_MTVAL:    csrReadData = mtval_q;
      CSR_MIP:      csrReadData = mip;
      CSR_MCYCLE:   csrReadData = mcycle_q;
      CSR_MINSTRET: csrReadData = minstret_q;
      default:      csrReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed plus randomized bench for csr_trap_unit against a cycle-level
// behavioural model of the machine-mode CSR/trap rules.
module tb_csr_trap_unit;
  localparam logic [31:0] RST_MTVEC = 32'h0000_0123;
  localparam int          SYNC      = 2;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305,
                          A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342,
                          A_MTVAL = 12'h343, A_MIP = 12'h344, A_MCYCLE = 12'hB00,
                          A_MINSTRET = 12'hB02, A_BOGUS = 12'h7C0;

  logic        clock = 1'b0, reset;
  logic [11:0] destinationCSR, csrWriteAddress;
  logic [31:0] csrReadData, csrWriteData, retireNextPC, exceptionPC, exceptionTval, trapTarget;
  logic        csrWriteEnable, retireValid, exceptionValid, mretCommit;
  logic [3:0]  exceptionCause;
  logic        softwareInterrupt, timerInterrupt, externalInterrupt;
  logic        trapRedirect, interruptPending;

  csr_trap_unit #(.RESET_MTVEC(RST_MTVEC), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset), .destinationCSR(destinationCSR), .csrReadData(csrReadData),
    .csrWriteEnable(csrWriteEnable), .csrWriteAddress(csrWriteAddress), .csrWriteData(csrWriteData),
    .retireValid(retireValid), .retireNextPC(retireNextPC), .exceptionValid(exceptionValid),
    .exceptionCause(exceptionCause), .exceptionPC(exceptionPC), .exceptionTval(exceptionTval),
    .mretCommit(mretCommit), .softwareInterrupt(softwareInterrupt), .timerInterrupt(timerInterrupt),
    .externalInterrupt(externalInterrupt), .trapRedirect(trapRedirect), .trapTarget(trapTarget),
    .interruptPending(interruptPending));

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;

  // reference state
  bit          m_gie, m_mpie, m_flush, m_sw, m_tm;
  bit          ext_hist[$];
  logic [31:0] m_ie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_mip();
    return (32'(ext_hist[SYNC-1]) << 11) | (32'(m_tm) << 7) | (32'(m_sw) << 3);
  endfunction

  function automatic bit m_pend();
    return m_gie && ((m_mip() & m_ie) != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      A_MSTATUS:  return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_gie) << 3);
      A_MIE:      return m_ie;
      A_MTVEC:    return m_mtvec;
      A_MSCRATCH: return m_mscratch;
      A_MEPC:     return m_mepc;
      A_MCAUSE:   return m_mcause;
      A_MTVAL:    return m_mtval;
      A_MIP:      return m_mip();
      A_MCYCLE:   return m_mcycle;
      A_MINSTRET: return m_minstret;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [11:0] pick_addr();
    logic [11:0] tbl [11] = '{A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
                             A_MTVAL, A_MIP, A_MCYCLE, A_MINSTRET, A_BOGUS};
    return tbl[$urandom_range(10, 0)];
  endfunction

  task automatic model_reset();
    m_gie = 0; m_mpie = 0; m_flush = 0; m_sw = 0; m_tm = 0;
    m_ie = 0; m_mtvec = RST_MTVEC & ~32'd3; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
    ext_hist = {};
    for (int i = 0; i < SYNC; i++) ext_hist.push_back(1'b0);
  endtask

  task automatic idle();
    csrWriteEnable = 0; csrWriteAddress = 0; csrWriteData = 0;
    retireValid = 0; retireNextPC = 0; exceptionValid = 0; exceptionCause = 0;
    exceptionPC = 0; exceptionTval = 0; mretCommit = 0;
  endtask

  // Advance one clock; the model applies the architectural rules to the
  // inputs present before the edge.
  task automatic tick();
    bit gie = m_gie, mpie = m_mpie, fl = 0;
    bit sw = softwareInterrupt, tm = timerInterrupt, ex = externalInterrupt;
    logic [31:0] ie = m_ie, tv = m_mtvec, sc = m_mscratch, ep = m_mepc, ca = m_mcause;
    logic [31:0] tl = m_mtval, cy = m_mcycle + 32'd1, ir = m_minstret;
    logic [31:0] act = m_mip() & m_ie;
    if (!m_flush) begin
      if (retireValid && !exceptionValid) ir = ir + 32'd1;
      if (exceptionValid) begin
        ep = exceptionPC; ca = {28'b0, exceptionCause}; tl = exceptionTval;
        mpie = gie; gie = 0; fl = 1;
      end else if (m_pend() && retireValid) begin
        ep = retireNextPC; tl = 0;
        ca = act[11] ? 32'h8000_000B : (act[3] ? 32'h8000_0003 : 32'h8000_0007);
        mpie = gie; gie = 0; fl = 1;
      end else if (mretCommit) begin
        gie = mpie; mpie = 1;
      end else if (csrWriteEnable) begin
        case (csrWriteAddress)
          A_MSTATUS:  begin gie = csrWriteData[3]; mpie = csrWriteData[7]; end
          A_MIE:      ie = csrWriteData & 32'h888;
          A_MTVEC:    tv = csrWriteData & ~32'd3;
          A_MSCRATCH: sc = csrWriteData;
          A_MEPC:     ep = csrWriteData & ~32'd3;
          A_MCAUSE:   ca = csrWriteData;
          A_MTVAL:    tl = csrWriteData;
          A_MCYCLE:   cy = csrWriteData;
          A_MINSTRET: ir = csrWriteData;
          default: ;
        endcase
      end
    end
    @(posedge clock);
    m_gie = gie; m_mpie = mpie; m_flush = fl; m_ie = ie; m_mtvec = tv; m_mscratch = sc;
    m_mepc = ep; m_mcause = ca; m_mtval = tl; m_mcycle = cy; m_minstret = ir;
    m_sw = sw; m_tm = tm;
    ext_hist.push_front(ex);
    void'(ext_hist.pop_back());
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    destinationCSR = a;
    #1;
    chk(tag, csrReadData, exp);
  endtask

  task automatic check_all();
    logic [11:0] a = pick_addr();
    chk("redirect", {31'b0, trapRedirect}, {31'b0, m_flush});
    chk("target", trapTarget, m_mtvec);
    chk("pending", {31'b0, interruptPending}, {31'b0, m_pend()});
    rd(a, m_read(a), $sformatf("model_rd_%03h", a));
  endtask

  task automatic cyc();
    tick();
    idle();
    check_all();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csrWriteEnable = 1; csrWriteAddress = a; csrWriteData = d;
    cyc();
  endtask

  task automatic raise_exc(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv);
    exceptionValid = 1; exceptionCause = c; exceptionPC = pc; exceptionTval = tv;
  endtask

  initial begin
    reset = 0; destinationCSR = 0;
    softwareInterrupt = 0; timerInterrupt = 0; externalInterrupt = 0;
    idle();
    repeat (3) @(posedge clock);
    #1 reset = 1;
    model_reset();

    // reset state and counting
    rd(A_MSTATUS, 32'h0000_1800, "rst_mstatus");
    rd(A_MTVEC, 32'h0000_0120, "rst_mtvec");
    chk("rst_redirect", {31'b0, trapRedirect}, 32'd0);
    rd(A_MCYCLE, 32'd0, "rst_mcycle0");
    for (int i = 1; i <= 3; i++) begin
      cyc();
      rd(A_MCYCLE, 32'(i), "rst_mcycle_n");
    end

    // write legalization
    wr(A_MSTATUS, 32'hFFFF_FFFF); rd(A_MSTATUS, 32'h0000_1888, "leg_mstatus");
    wr(A_MIP, 32'hFFFF_FFFF);     rd(A_MIP, 32'h0, "leg_mip");
    wr(A_MEPC, 32'h1003);         rd(A_MEPC, 32'h1000, "leg_mepc");
    wr(A_MIE, 32'hFFFF_FFFF);     rd(A_MIE, 32'h888, "leg_mie");
    wr(A_MIE, 32'h0);

    // exception trap
    wr(A_MTVEC, 32'h100);
    wr(A_MSTATUS, 32'h8);
    raise_exc(4'd2, 32'h40, 32'hDEAD);
    cyc();
    chk("exc_redirect", {31'b0, trapRedirect}, 32'd1);
    chk("exc_target", trapTarget, 32'h100);
    rd(A_MEPC, 32'h40, "exc_mepc");
    rd(A_MCAUSE, 32'h2, "exc_mcause");
    rd(A_MTVAL, 32'hDEAD, "exc_mtval");
    rd(A_MSTATUS, 32'h1880, "exc_mstatus");
    cyc();
    chk("exc_redirect_off", {31'b0, trapRedirect}, 32'd0);

    // interrupt priority after synchronizer latency
    wr(A_MIE, 32'h888);
    wr(A_MSTATUS, 32'h8);
    softwareInterrupt = 1; timerInterrupt = 1; externalInterrupt = 1;
    repeat (SYNC + 1) cyc();
    retireValid = 1; retireNextPC = 32'h200;
    cyc();
    rd(A_MCAUSE, 32'h8000_000B, "irq_mcause");
    rd(A_MEPC, 32'h200, "irq_mepc");
    rd(A_MTVAL, 32'h0, "irq_mtval");
    softwareInterrupt = 0; timerInterrupt = 0; externalInterrupt = 0;
    cyc();

    // MRET, then counter collisions
    mretCommit = 1;
    cyc();
    rd(A_MSTATUS, 32'h1888, "mret_mstatus");
    wr(A_MIE, 32'h0);
    repeat (SYNC + 1) cyc();
    csrWriteEnable = 1; csrWriteAddress = A_MINSTRET; csrWriteData = 32'd5; retireValid = 1;
    cyc();
    rd(A_MINSTRET, 32'd5, "instret_wr_wins");
    retireValid = 1;
    cyc();
    rd(A_MINSTRET, 32'd6, "instret_inc");
    wr(A_MCYCLE, 32'hFFFF_FFFF);
    rd(A_MCYCLE, 32'hFFFF_FFFF, "mcycle_max");
    cyc();
    rd(A_MCYCLE, 32'h0, "mcycle_wrap");

    // simultaneous events and exception during FLUSH
    wr(A_MSCRATCH, 32'h55);
    raise_exc(4'd5, 32'h80, 32'h1);
    csrWriteEnable = 1; csrWriteAddress = A_MSCRATCH; csrWriteData = 32'd7;
    cyc();
    rd(A_MSCRATCH, 32'h55, "sim_mscratch");
    chk("sim_redirect", {31'b0, trapRedirect}, 32'd1);
    raise_exc(4'd7, 32'h999C, 32'h2);
    cyc();
    rd(A_MEPC, 32'h80, "flush_exc_ignored");
    chk("flush_redirect_off", {31'b0, trapRedirect}, 32'd0);

    // asynchronous reset during FLUSH
    raise_exc(4'd1, 32'h10, 32'h0);
    cyc();
    chk("ar_redirect_on", {31'b0, trapRedirect}, 32'd1);
    #2 reset = 0;
    #1 chk("ar_redirect_drop", {31'b0, trapRedirect}, 32'd0);
    rd(A_MSTATUS, 32'h1800, "ar_mstatus");
    @(posedge clock);
    #1 reset = 1;
    model_reset();
    check_all();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15, 0) == 0) softwareInterrupt = ~softwareInterrupt;
      if ($urandom_range(15, 0) == 0) timerInterrupt    = ~timerInterrupt;
      if ($urandom_range(15, 0) == 0) externalInterrupt = ~externalInterrupt;
      retireValid  = ($urandom_range(1, 0) == 0);
      retireNextPC = $urandom;
      if ($urandom_range(9, 0) == 0) raise_exc(4'($urandom), $urandom, $urandom);
      mretCommit = ($urandom_range(7, 0) == 0);
      if ($urandom_range(2, 0) == 0) begin
        csrWriteEnable  = 1;
        csrWriteAddress = pick_addr();
        csrWriteData    = $urandom;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
